// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared fetch/decode definitions.
//   XLEN           - address width
//   NOP            - canonical no-op encoding (addi x0,x0,0)
//   INST_BUF_SIZE  - default buffer depth, shared by ifetch and inst_buffer
//   IF_ID_PACKET   - packet handed from ifetch to decode
//   NOP_PACKET     - defined packet shown when no entry is present
package inst_buffer_pkg;

  localparam int          XLEN          = 32;
  localparam logic [31:0] NOP           = 32'h0000_0013;
  localparam int          INST_BUF_SIZE = 8;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] NPC;
    logic            valid;
  } IF_ID_PACKET;

  localparam IF_ID_PACKET NOP_PACKET = '{inst: NOP, PC: '0, NPC: '0, valid: 1'b0};

endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: FIFO of IF_ID_PACKETs between ifetch and decode.
// Ports:
//   clock, reset (async, active low)
//   if_packet  in   packet from ifetch, .valid = push request
//   flush      in   synchronous discard of all entries (beats push/pop)
//   id_ready   in   decode takes id_packet this cycle
//   if_valid   out  buffer can take a push this cycle
//   id_packet  out  head entry (combinational), NOP packet when empty
//   count/full/empty out  occupancy status
// Optional: define INST_BUF_BYPASS_EN to forward if_packet straight to
// id_packet when the buffer is empty and decode is ready (0-cycle latency).
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter  int DEPTH = INST_BUF_SIZE,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  IF_ID_PACKET      if_packet,
  input  logic             flush,
  input  logic             id_ready,
  output logic             if_valid,
  output IF_ID_PACKET      id_packet,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  IF_ID_PACKET            r_mem [DEPTH];
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [PTR_W:0]         r_count;

  logic w_empty, w_full, w_pop, w_push, w_bypass;

  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == (PTR_W+1)'(DEPTH));
`ifdef INST_BUF_BYPASS_EN
    // Empty buffer with decode ready: hand the packet over directly and
    // leave storage/pointers untouched.
    w_bypass = w_empty && if_packet.valid && id_ready && !flush;
`else
    w_bypass = 1'b0;
`endif
    w_pop  = id_ready && !w_empty;
    // A full buffer still accepts a push when a pop frees the slot this cycle.
    w_push = if_packet.valid && (!w_full || w_pop) && !w_bypass;
  end

  always_comb begin
    id_packet = NOP_PACKET;
    if (w_bypass) begin
      id_packet = if_packet;
    end else if (!w_empty) begin
      id_packet       = r_mem[r_head];
      id_packet.valid = 1'b1;
    end
  end

  assign if_valid = !w_full || id_ready;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push) r_tail <= r_tail + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clock) begin
    if (w_push && !flush) r_mem[r_tail] <= if_packet;
  end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  IF_ID_PACKET if_packet;
  logic        flush;
  logic        id_ready;
  logic        if_valid;
  IF_ID_PACKET id_packet;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  inst_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .if_packet(if_packet), .flush(flush),
    .id_ready(id_ready), .if_valid(if_valid), .id_packet(id_packet),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  function automatic IF_ID_PACKET mk(input logic [31:0] pc);
    IF_ID_PACKET p;
    p.inst  = 32'h0010_0093 ^ pc;
    p.PC    = pc;
    p.NPC   = pc + 32'd4;
    p.valid = 1'b1;
    return p;
  endfunction

  // Drive inputs just after a negedge and let combinational outputs settle.
  task automatic set_in(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    if_packet = mk(pc);
    if_packet.valid = v;
    id_ready = rdy;
    flush = fl;
    #1;
  endtask

  // Commit one clock edge; return at the following negedge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clock); #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || if_valid !== 1'b1 || id_packet.valid !== 1'b0 ||
        id_packet.inst !== NOP || id_packet.PC !== 32'h0 || id_packet.NPC !== 32'h0) begin
      failures++;
      $display("FAIL reset_hold: empty=%b full=%b if_valid=%b valid=%b inst=%h PC=%h NPC=%h want 1 0 1 0 %h 0 0",
               empty, full, if_valid, id_packet.valid, id_packet.inst, id_packet.PC, id_packet.NPC, NOP);
    end
    reset = 1'b1;
    step(); #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || if_valid !== 1'b1 || id_packet.valid !== 1'b0 || id_packet.inst !== NOP) begin
      failures++;
      $display("FAIL reset_release: count=%0d empty=%b if_valid=%b valid=%b inst=%h want 0 1 1 0 %h",
               count, empty, if_valid, id_packet.valid, id_packet.inst, NOP);
    end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(i*4), 1'b0, 1'b0);
      step();
    end
    #1;
    checks++;
    if (count !== 4'd3) begin
      failures++;
      $display("FAIL pp_count: count=%0d want 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (id_packet.valid !== 1'b1 || id_packet.PC !== 32'(i*4) || id_packet.NPC !== 32'(i*4+4)) begin
        failures++;
        $display("FAIL pp_order[%0d]: valid=%b PC=%h NPC=%h want 1 %h %h",
                 i, id_packet.valid, id_packet.PC, id_packet.NPC, i*4, i*4+4);
      end
      step();
    end
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || id_packet.valid !== 1'b0 || id_packet.inst !== NOP) begin
      failures++;
      $display("FAIL pp_drained: empty=%b count=%0d valid=%b inst=%h want 1 0 0 %h",
               empty, count, id_packet.valid, id_packet.inst, NOP);
    end
  endtask

  task automatic test_pop_empty();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    step(); step(); #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty: count=%0d empty=%b full=%b want 0 1 0", count, empty, full);
    end
  endtask

`ifndef INST_BUF_BYPASS_EN
  task automatic test_latency();
    set_in(1'b1, 32'h80, 1'b1, 1'b0);
    checks++;
    if (id_packet.valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_same_cycle: valid=%b want 0", id_packet.valid);
    end
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (id_packet.valid !== 1'b1 || id_packet.PC !== 32'h80 || count !== 4'd1) begin
      failures++;
      $display("FAIL lat_next_cycle: valid=%b PC=%h count=%0d want 1 80 1", id_packet.valid, id_packet.PC, count);
    end
    step();
  endtask
`endif

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'(i*4), 1'b0, 1'b0);
      step();
    end
    set_in(1'b1, 32'h20, 1'b0, 1'b0);
    checks++;
    if (full !== 1'b1 || if_valid !== 1'b0 || count !== 4'd8) begin
      failures++;
      $display("FAIL full_flags: full=%b if_valid=%b count=%0d want 1 0 8", full, if_valid, count);
    end
    step();  // 9th push must be ignored
    #1;
    checks++;
    if (count !== 4'd8 || id_packet.PC !== 32'h0) begin
      failures++;
      $display("FAIL full_ignore: count=%0d headPC=%h want 8 0", count, id_packet.PC);
    end
    set_in(1'b1, 32'h40, 1'b1, 1'b0);
    checks++;
    if (if_valid !== 1'b1 || id_packet.PC !== 32'h0) begin
      failures++;
      $display("FAIL full_pushpop_pre: if_valid=%b PC=%h want 1 0", if_valid, id_packet.PC);
    end
    step(); #1;
    checks++;
    if (count !== 4'd8 || full !== 1'b1) begin
      failures++;
      $display("FAIL full_pushpop_cnt: count=%0d full=%b want 8 1", count, full);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i < 7) ? 32'((i+1)*4) : 32'h40;
      set_in(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (id_packet.valid !== 1'b1 || id_packet.PC !== exp_pc) begin
        failures++;
        $display("FAIL full_drain[%0d]: valid=%b PC=%h want 1 %h", i, id_packet.valid, id_packet.PC, exp_pc);
      end
      step();
    end
    #1;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drained: empty=%b want 1", empty);
    end
  endtask

  task automatic test_stream();
    set_in(1'b1, 32'h1000, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'h1000 + 32'((i+1)*4), 1'b1, 1'b0);
      checks++;
      if (id_packet.valid !== 1'b1 || id_packet.PC !== 32'h1000 + 32'(i*4)) begin
        failures++;
        $display("FAIL stream_pc[%0d]: valid=%b PC=%h want 1 %h", i, id_packet.valid, id_packet.PC, 32'h1000 + i*4);
      end
      step(); #1;
      checks++;
      if (count !== 4'd1) begin
        failures++;
        $display("FAIL stream_cnt[%0d]: count=%0d want 1", i, count);
      end
    end
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (id_packet.PC !== 32'h1050) begin
      failures++;
      $display("FAIL stream_last: PC=%h want 1050", id_packet.PC);
    end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'hA0 + 32'(i*4), 1'b0, 1'b0);
      step();
    end
    #1;
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL flush_pre: count=%0d want 5", count);
    end
    set_in(1'b1, 32'h100, 1'b1, 1'b1);
    checks++;
    if (id_packet.PC !== 32'hA0 || id_packet.valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_cycle_head: PC=%h valid=%b want a0 1", id_packet.PC, id_packet.valid);
    end
    step(); #1;
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || id_packet.valid !== 1'b0 || id_packet.inst !== NOP) begin
      failures++;
      $display("FAIL flush_after: count=%0d empty=%b valid=%b inst=%h want 0 1 0 %h",
               count, empty, id_packet.valid, id_packet.inst, NOP);
    end
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    step(); #1;
    checks++;
    if (id_packet.valid !== 1'b0 || id_packet.PC === 32'h100) begin
      failures++;
      $display("FAIL flush_dropped: valid=%b PC=%h want 0 and not 100", id_packet.valid, id_packet.PC);
    end
    set_in(1'b1, 32'h300, 1'b0, 1'b0);
    step();
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (id_packet.valid !== 1'b1 || id_packet.PC !== 32'h300 || count !== 4'd1) begin
      failures++;
      $display("FAIL flush_resume: valid=%b PC=%h count=%0d want 1 300 1", id_packet.valid, id_packet.PC, count);
    end
    step();
  endtask

`ifdef INST_BUF_BYPASS_EN
  task automatic test_bypass();
    set_in(1'b1, 32'h200, 1'b1, 1'b0);
    checks++;
    if (id_packet.valid !== 1'b1 || id_packet.PC !== 32'h200) begin
      failures++;
      $display("FAIL bypass_same: valid=%b PC=%h want 1 200", id_packet.valid, id_packet.PC);
    end
    step(); #1;
    set_in(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd0 || empty !== 1'b1 || id_packet.valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_nostore: count=%0d empty=%b valid=%b want 0 1 0", count, empty, id_packet.valid);
    end
  endtask
`endif

  initial begin
    if_packet = NOP_PACKET;
    flush = 1'b0;
    id_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_push_pop();
    test_pop_empty();
`ifndef INST_BUF_BYPASS_EN
    test_latency();
`endif
    test_full();
    test_stream();
    test_flush();
`ifdef INST_BUF_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
